// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 framebuffer stream writer: FSM state
// encoding and the line/column counter width helpers.
package hub75_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] ST_FILL     = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT_RDY = 3'd2;
   localparam logic [STATE_W-1:0] ST_SWAP     = 3'd3;
   localparam logic [STATE_W-1:0] ST_STORE    = 3'd4;
   localparam logic [STATE_W-1:0] ST_FLUSH    = 3'd5;
   localparam logic [STATE_W-1:0] ST_FSWAP    = 3'd6;

   // Line counter spans every row of every bank in one frame.
   function automatic int lineCtrWidth(input int nBanks, input int nRows);
      return $clog2(nBanks * nRows);
   endfunction

   function automatic int colCtrWidth(input int nCols);
      return $clog2(nCols);
   endfunction

endpackage

// File: rtl/hub75_fb_stream_writer.sv
// Converts a raster pixel stream into line-buffer writes, row store requests
// and a framebuffer flip once every line of a frame has been stored.
module hub75_fb_stream_writer #(
   parameter int N_BANKS     = 2,
   parameter int N_ROWS      = 32,
   parameter int N_COLS      = 64,
   parameter int BITDEPTH    = 24,
   parameter int LOG_N_BANKS = $clog2(N_BANKS),
   parameter int LOG_N_ROWS  = $clog2(N_ROWS),
   parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [BITDEPTH-1:0]    in_data,
   input  logic                   in_sof,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [LOG_N_BANKS-1:0] wr_bank_addr,
   output logic [LOG_N_ROWS-1:0]  wr_row_addr,
   output logic                   wr_row_store,
   input  logic                   wr_row_rdy,
   output logic                   wr_row_swap,
   output logic [BITDEPTH-1:0]    wr_data,
   output logic [LOG_N_COLS-1:0]  wr_col_addr,
   output logic                   wr_en,
   output logic                   frame_swap,
   output logic                   err_sof
);

   import hub75_pkg::*;

   localparam int LINE_W = lineCtrWidth(N_BANKS, N_ROWS);
   localparam int COL_W  = colCtrWidth(N_COLS);

   localparam logic [LINE_W-1:0]     LAST_LINE = LINE_W'(N_BANKS * N_ROWS - 1);
   localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(N_COLS - 1);
   localparam logic [LOG_N_ROWS-1:0] LAST_ROW  = LOG_N_ROWS'(N_ROWS - 1);

   logic [STATE_W-1:0]     state_q, state_d;
   logic [LINE_W-1:0]      line_q, line_d;
   logic [LOG_N_BANKS-1:0] bank_q, bank_d;
   logic [LOG_N_ROWS-1:0]  row_q, row_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic                   flushFirst_q, flushFirst_d;
   logic                   pend_q, pend_d;

   logic                   inReady_q, inReady_d;
   logic                   wrEn_q, wrEn_d;
   logic [BITDEPTH-1:0]    wrData_q, wrData_d;
   logic [LOG_N_COLS-1:0]  wrCol_q, wrCol_d;
   logic [LOG_N_BANKS-1:0] wrBank_q, wrBank_d;
   logic [LOG_N_ROWS-1:0]  wrRow_q, wrRow_d;
   logic                   rowSwap_q, rowSwap_d;
   logic                   rowStore_q, rowStore_d;
   logic                   frameSwap_q, frameSwap_d;
   logic                   errSof_q, errSof_d;

   logic                   accept;
   logic                   takePixel;
   logic                   sofRestart;
   logic [COL_W-1:0]       pixCol;

   // Next-state logic. A mid-frame SOF raises err_sof first and writes its
   // pixel one cycle later (pend_q) so no two strobes ever share a cycle.
   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      bank_d       = bank_q;
      row_d        = row_q;
      col_d        = col_q;
      flushFirst_d = 1'b0;
      pend_d       = 1'b0;
      wrEn_d       = pend_q;
      wrData_d     = wrData_q;
      wrCol_d      = wrCol_q;
      wrBank_d     = wrBank_q;
      wrRow_d      = wrRow_q;
      errSof_d     = 1'b0;
      accept       = in_valid && inReady_q;
      takePixel    = 1'b0;
      sofRestart   = 1'b0;
      pixCol       = col_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (in_sof) begin
                  takePixel = 1'b1;
                  pixCol    = '0;
                  line_d    = '0;
                  bank_d    = '0;
                  row_d     = '0;
               end else begin
                  errSof_d = 1'b1;
               end
            end
         end
         ST_FILL: begin
            if (accept) begin
               takePixel = 1'b1;
               if (in_sof && !(line_q == '0 && col_q == '0)) begin
                  errSof_d   = 1'b1;
                  sofRestart = 1'b1;
                  pend_d     = 1'b1;
                  pixCol     = '0;
                  line_d     = '0;
                  bank_d     = '0;
                  row_d      = '0;
               end
            end
         end
         ST_WAIT_RDY: begin
            if (wr_row_rdy && !pend_q) begin
               state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            state_d  = ST_STORE;
            wrBank_d = bank_q;
            wrRow_d  = row_q;
         end
         ST_STORE: begin
            if (line_q == LAST_LINE) begin
               state_d      = ST_FLUSH;
               flushFirst_d = 1'b1;
            end else begin
               state_d = ST_FILL;
               line_d  = line_q + 1'b1;
               col_d   = '0;
               if (row_q == LAST_ROW) begin
                  row_d  = '0;
                  bank_d = bank_q + 1'b1;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         ST_FLUSH: begin
            // The store engine may not have dropped rdy yet on the first cycle.
            if (!flushFirst_q && wr_row_rdy) begin
               state_d = ST_FSWAP;
            end
         end
         ST_FSWAP: begin
            state_d = ST_IDLE;
            line_d  = '0;
            bank_d  = '0;
            row_d   = '0;
            col_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (takePixel) begin
         wrData_d = in_data;
         wrCol_d  = pixCol;
         wrEn_d   = !sofRestart;
         if (pixCol == LAST_COL) begin
            state_d = ST_WAIT_RDY;
         end else begin
            state_d = ST_FILL;
            col_d   = pixCol + 1'b1;
         end
      end

      rowSwap_d   = (state_d == ST_SWAP);
      rowStore_d  = (state_d == ST_STORE);
      frameSwap_d = (state_d == ST_FSWAP);
      inReady_d   = (state_d == ST_IDLE || state_d == ST_FILL) && !pend_d;
   end

   // State, counters and every output are registered; reset clears all.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         line_q       <= '0;
         bank_q       <= '0;
         row_q        <= '0;
         col_q        <= '0;
         flushFirst_q <= 1'b0;
         pend_q       <= 1'b0;
         inReady_q    <= 1'b0;
         wrEn_q       <= 1'b0;
         wrData_q     <= '0;
         wrCol_q      <= '0;
         wrBank_q     <= '0;
         wrRow_q      <= '0;
         rowSwap_q    <= 1'b0;
         rowStore_q   <= 1'b0;
         frameSwap_q  <= 1'b0;
         errSof_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         line_q       <= line_d;
         bank_q       <= bank_d;
         row_q        <= row_d;
         col_q        <= col_d;
         flushFirst_q <= flushFirst_d;
         pend_q       <= pend_d;
         inReady_q    <= inReady_d;
         wrEn_q       <= wrEn_d;
         wrData_q     <= wrData_d;
         wrCol_q      <= wrCol_d;
         wrBank_q     <= wrBank_d;
         wrRow_q      <= wrRow_d;
         rowSwap_q    <= rowSwap_d;
         rowStore_q   <= rowStore_d;
         frameSwap_q  <= frameSwap_d;
         errSof_q     <= errSof_d;
      end
   end

   assign in_ready     = inReady_q;
   assign wr_en        = wrEn_q;
   assign wr_data      = wrData_q;
   assign wr_col_addr  = wrCol_q;
   assign wr_bank_addr = wrBank_q;
   assign wr_row_addr  = wrRow_q;
   assign wr_row_swap  = rowSwap_q;
   assign wr_row_store = rowStore_q;
   assign frame_swap   = frameSwap_q;
   assign err_sof      = errSof_q;

endmodule
